// File: rtl/vga_pkg.sv
// Shared VGA sprite-path definitions: melee sequencer state encoding and
// default melee timing values used as parameter defaults by melee_attack_ctrl.
package vga_pkg;

    typedef enum logic [1:0] {
        MELEE_IDLE     = 2'd0,
        MELEE_SWING    = 2'd1,
        MELEE_RECOVER  = 2'd2,
        MELEE_COOLDOWN = 2'd3
    } melee_state_t;

    localparam int unsigned MELEE_SWING_FRAMES    = 8;
    localparam int unsigned MELEE_STEP_PX         = 4;
    localparam int unsigned MELEE_RECOVER_FRAMES  = 4;
    localparam int unsigned MELEE_COOLDOWN_FRAMES = 10;
    localparam int unsigned MELEE_HIT_FIRST       = 2;
    localparam int unsigned MELEE_HIT_LAST        = 5;
    localparam int unsigned MELEE_OFFSET_W        = 12;

    // Per-frame offset decrement during recovery: peak offset spread over the
    // recovery frames; the remainder is dropped by forcing 0 on the last frame.
    function automatic int unsigned melee_recover_step(
        input int unsigned swing_frames,
        input int unsigned step_px,
        input int unsigned recover_frames
    );
        return ((swing_frames - 1) * step_px) / recover_frames;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector with asynchronous active-high reset.
// rise is a one-clock pulse when sig goes 0 -> 1 (sig must already be in clk domain).
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Delay the input by one clock to compare against its previous level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/melee_attack_ctrl.sv
// Melee attack sequencer: turns left-click into a frame-timed swing
// (SWING -> RECOVER -> COOLDOWN) driving the melee weapon draw stage.
// Optional build macro: MELEE_CLICK_BUFFER_EN (one-deep click buffer for
// clicks arriving during RECOVER/COOLDOWN).
module melee_attack_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned SWING_FRAMES    = MELEE_SWING_FRAMES,
    parameter int unsigned STEP_PX         = MELEE_STEP_PX,
    parameter int unsigned RECOVER_FRAMES  = MELEE_RECOVER_FRAMES,
    parameter int unsigned COOLDOWN_FRAMES = MELEE_COOLDOWN_FRAMES,
    parameter int unsigned HIT_FIRST       = MELEE_HIT_FIRST,
    parameter int unsigned HIT_LAST        = MELEE_HIT_LAST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        mouse_left,
    input  logic        flip_hor,
    input  logic [1:0]  game_active,
    output logic        attack_active,
    output logic [11:0] anim_x_offset,
    output logic        flip_hor_melee,
    output logic        hit_window,
    output logic        busy,
    output logic [7:0]  attack_cnt
);

    localparam logic [3:0]  SWING_LAST    = 4'(SWING_FRAMES - 1);
    localparam logic [3:0]  RECOVER_LAST  = 4'(RECOVER_FRAMES - 1);
    localparam logic [3:0]  COOLDOWN_LAST = 4'(COOLDOWN_FRAMES - 1);
    localparam logic [3:0]  HIT_FIRST_C   = 4'(HIT_FIRST);
    localparam logic [3:0]  HIT_LAST_C    = 4'(HIT_LAST);
    localparam logic [11:0] STEP_C        = 12'(STEP_PX);
    localparam logic [11:0] DEC_C         =
        12'(melee_recover_step(SWING_FRAMES, STEP_PX, RECOVER_FRAMES));

    melee_state_t state_q, state_d;

    logic        frame_tick;
    logic        click;
    logic        game_on;
    logic        start_req;

    logic [3:0]  frame_cnt, cnt_d;
    logic [11:0] off_d;
    logic        act_d;
    logic        flip_d;
    logic        hit_d;
    logic [7:0]  acnt_d;

    edge_detect u_tick_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (vblnk),
        .rise (frame_tick)
    );

    edge_detect u_click_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (mouse_left),
        .rise (click)
    );

    assign game_on = |game_active;

`ifdef MELEE_CLICK_BUFFER_EN
    logic click_pending, pending_d;

    assign start_req = click | click_pending;

    // Remember one click made while the weapon is recovering or cooling down
    always_comb begin
        pending_d = click_pending;
        if (!game_on) begin
            pending_d = 1'b0;
        end else if (state_q == MELEE_IDLE && start_req) begin
            pending_d = 1'b0;
        end else if ((state_q == MELEE_RECOVER || state_q == MELEE_COOLDOWN) && click) begin
            pending_d = 1'b1;
        end
    end

    // Click buffer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            click_pending <= 1'b0;
        end else begin
            click_pending <= pending_d;
        end
    end
`else
    assign start_req = click;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MELEE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: frame ticks pace each phase, game stop forces IDLE
    always_comb begin
        state_d = state_q;
        if (!game_on) begin
            state_d = MELEE_IDLE;
        end else begin
            case (state_q)
                MELEE_IDLE: begin
                    if (start_req) state_d = MELEE_SWING;
                end
                MELEE_SWING: begin
                    if (frame_tick && frame_cnt == SWING_LAST) state_d = MELEE_RECOVER;
                end
                MELEE_RECOVER: begin
                    if (frame_tick && frame_cnt == RECOVER_LAST)
                        state_d = (COOLDOWN_FRAMES == 0) ? MELEE_IDLE : MELEE_COOLDOWN;
                end
                MELEE_COOLDOWN: begin
                    if (frame_tick && frame_cnt == COOLDOWN_LAST) state_d = MELEE_IDLE;
                end
                default: state_d = MELEE_IDLE;
            endcase
        end
    end

    // Output logic: next values of the frame counter and registered outputs
    always_comb begin
        cnt_d  = frame_cnt;
        off_d  = anim_x_offset;
        act_d  = attack_active;
        flip_d = flip_hor_melee;
        acnt_d = attack_cnt;
        if (!game_on) begin
            cnt_d = '0;
            off_d = '0;
            act_d = 1'b0;
        end else begin
            case (state_q)
                MELEE_IDLE: begin
                    if (start_req) begin
                        cnt_d  = '0;
                        off_d  = '0;
                        act_d  = 1'b1;
                        flip_d = flip_hor;
                        acnt_d = attack_cnt + 8'd1;
                    end
                end
                MELEE_SWING: begin
                    // The last swing tick only changes phase, so the offset peaks
                    // at (SWING_FRAMES-1)*STEP_PX.
                    if (frame_tick) begin
                        if (frame_cnt == SWING_LAST) begin
                            cnt_d = '0;
                        end else begin
                            cnt_d = frame_cnt + 4'd1;
                            off_d = anim_x_offset + STEP_C;
                        end
                    end
                end
                MELEE_RECOVER: begin
                    if (frame_tick) begin
                        if (frame_cnt == RECOVER_LAST) begin
                            cnt_d = '0;
                            off_d = '0;
                            act_d = 1'b0;
                        end else begin
                            cnt_d = frame_cnt + 4'd1;
                            off_d = anim_x_offset - DEC_C;
                        end
                    end
                end
                MELEE_COOLDOWN: begin
                    act_d = 1'b0;
                    if (frame_tick) begin
                        cnt_d = (frame_cnt == COOLDOWN_LAST) ? 4'd0 : frame_cnt + 4'd1;
                    end
                end
                default: begin
                    cnt_d = '0;
                    off_d = '0;
                    act_d = 1'b0;
                end
            endcase
        end
        hit_d = (state_d == MELEE_SWING) && (cnt_d >= HIT_FIRST_C) && (cnt_d <= HIT_LAST_C);
    end

    // Output and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt      <= '0;
            anim_x_offset  <= '0;
            attack_active  <= 1'b0;
            flip_hor_melee <= 1'b0;
            hit_window     <= 1'b0;
            busy           <= 1'b0;
            attack_cnt     <= '0;
        end else begin
            frame_cnt      <= cnt_d;
            anim_x_offset  <= off_d;
            attack_active  <= act_d;
            flip_hor_melee <= flip_d;
            hit_window     <= hit_d;
            busy           <= (state_d != MELEE_IDLE);
            attack_cnt     <= acnt_d;
        end
    end

endmodule

// File: tb/tb_melee_attack_ctrl.sv
// Self-checking bench for melee_attack_ctrl (default parameters).
// Each step drives one clock with the stimulus and one quiet clock, checking
// registered outputs after both against scoreboard expectations.
module tb_melee_attack_ctrl;

    localparam int SWING   = 8;
    localparam int STEP    = 4;
    localparam int RECOVER = 4;
    localparam int COOL    = 10;
    localparam int HIT_F   = 2;
    localparam int HIT_L   = 5;
    localparam int PEAK    = (SWING - 1) * STEP;
    localparam int DEC     = PEAK / RECOVER;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vblnk = 1'b0;
    logic        mouse_left = 1'b0;
    logic        flip_hor = 1'b0;
    logic [1:0]  game_active = 2'b00;
    logic        attack_active;
    logic [11:0] anim_x_offset;
    logic        flip_hor_melee;
    logic        hit_window;
    logic        busy;
    logic [7:0]  attack_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        act;
        logic [11:0] off;
        logic        fm;
        logic        hit;
        logic        busy;
        logic [7:0]  acnt;
    } exp_t;

    typedef struct {
        logic       tick;
        logic       click;
        logic       flip;
        logic [1:0] ga;
        exp_t       ea;
        exp_t       eb;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];

    melee_attack_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .vblnk          (vblnk),
        .mouse_left     (mouse_left),
        .flip_hor       (flip_hor),
        .game_active    (game_active),
        .attack_active  (attack_active),
        .anim_x_offset  (anim_x_offset),
        .flip_hor_melee (flip_hor_melee),
        .hit_window     (hit_window),
        .busy           (busy),
        .attack_cnt     (attack_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic exp_t mk(bit act, int off, bit fm, bit hit, bit bsy, int acnt);
        exp_t e;
        e.act  = act;
        e.off  = 12'(off);
        e.fm   = fm;
        e.hit  = hit;
        e.busy = bsy;
        e.acnt = 8'(acnt);
        return e;
    endfunction

    function automatic void chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endfunction

    function automatic void compare(string nm, exp_t e);
        chk({nm, ".attack_active"},  int'(attack_active),  int'(e.act));
        chk({nm, ".anim_x_offset"},  int'(anim_x_offset),  int'(e.off));
        chk({nm, ".flip_hor_melee"}, int'(flip_hor_melee), int'(e.fm));
        chk({nm, ".hit_window"},     int'(hit_window),     int'(e.hit));
        chk({nm, ".busy"},           int'(busy),           int'(e.busy));
        chk({nm, ".attack_cnt"},     int'(attack_cnt),     int'(e.acnt));
    endfunction

    task automatic clock_and_check(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL %s scoreboard empty got=0 want=1", nm);
        end else begin
            e = sb.pop_front();
            compare(nm, e);
        end
    endtask

    task automatic drive(input logic tick, input logic click, input logic flip,
                         input logic [1:0] ga, input exp_t ea, input exp_t eb,
                         input string nm);
        vblnk       = tick;
        mouse_left  = click;
        flip_hor    = flip;
        game_active = ga;
        sb.push_back(ea);
        clock_and_check({nm, "/a"});
        vblnk      = 1'b0;
        mouse_left = 1'b0;
        sb.push_back(eb);
        clock_and_check({nm, "/b"});
    endtask

    function automatic void add_vec(bit tick, bit click, bit flip, logic [1:0] ga, exp_t e);
        vec_t v;
        v.tick  = tick;
        v.click = click;
        v.flip  = flip;
        v.ga    = ga;
        v.ea    = e;
        v.eb    = e;
        vecs.push_back(v);
    endfunction

    // One full attack: click, swing ticks, recovery ticks, cooldown ticks.
    // flip_hor switches from f0 to f1 at swing tick 3; extra adds ignored clicks
    // at recovery tick 1 and at cooldown start.
    function automatic void build_attack(bit f0, bit f1, logic [1:0] ga, int acnt, bit extra);
        add_vec(0, 1, f0, ga, mk(1, 0, f0, 0, 1, acnt));
        for (int n = 1; n < SWING; n++)
            add_vec(1, 0, (n >= 3) ? f1 : f0, ga,
                    mk(1, STEP * n, f0, (n >= HIT_F && n <= HIT_L), 1, acnt));
        add_vec(1, 0, f1, ga, mk(1, PEAK, f0, 0, 1, acnt));
        for (int r = 1; r <= RECOVER; r++)
            add_vec(1, extra && (r == 1), f1, ga,
                    mk(r != RECOVER, (r == RECOVER) ? 0 : PEAK - DEC * r, f0, 0, 1, acnt));
        if (extra)
            add_vec(0, 1, f1, ga, mk(0, 0, f0, 0, 1, acnt));
        for (int c = 1; c <= COOL; c++)
            add_vec(1, 0, f1, ga, mk(0, 0, f0, 0, c < COOL, acnt));
    endfunction

    initial begin
        exp_t e;

        build_attack(1'b0, 1'b0, 2'b01, 1, 1'b0);
        build_attack(1'b1, 1'b0, 2'b10, 2, 1'b1);
`ifdef MELEE_CLICK_BUFFER_EN
        vecs[vecs.size() - 1].eb = mk(1, 0, 0, 0, 1, 3);
`endif

        @(posedge clk);
        #1;
        compare("reset", mk(0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            drive(vecs[i].tick, vecs[i].click, vecs[i].flip, vecs[i].ga,
                  vecs[i].ea, vecs[i].eb, $sformatf("vec%0d", i));

`ifndef MELEE_CLICK_BUFFER_EN
        e = mk(1, 0, 0, 0, 1, 3);
        drive(0, 1, 0, 2'b11, e, e, "restart");
`endif
        for (int n = 1; n <= 4; n++) begin
            e = mk(1, STEP * n, 0, (n >= HIT_F && n <= HIT_L), 1, 3);
            drive(1, 0, 0, 2'b11, e, e, $sformatf("abort_swing%0d", n));
        end
        e = mk(0, 0, 0, 0, 0, 3);
        drive(0, 0, 0, 2'b00, e, e, "abort");
        drive(0, 1, 0, 2'b00, e, e, "click_inactive");

        e = mk(1, 0, 0, 0, 1, 4);
        drive(0, 1, 0, 2'b01, e, e, "pre_reset_start");
        e = mk(1, 4, 0, 0, 1, 4);
        drive(1, 0, 0, 2'b01, e, e, "pre_reset_t1");
        e = mk(1, 8, 0, 1, 1, 4);
        drive(1, 0, 0, 2'b01, e, e, "pre_reset_t2");

        #2;
        rst = 1'b1;
        #1;
        compare("async_reset", mk(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        e = mk(1, 0, 1, 0, 1, 1);
        drive(0, 1, 1, 2'b01, e, e, "post_reset_start");
        e = mk(1, 4, 1, 0, 1, 1);
        drive(1, 0, 1, 2'b01, e, e, "post_reset_t1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/melee_attack_ctrl.md
Name: melee_attack_ctrl

Overview:
Sequencer for the melee weapon sprite path. It turns raw left-mouse input into a timed swing: attack-active strobe, per-frame animation offset and latched facing direction, which feed the melee weapon draw stage. It also emits a hit-window flag for collision logic and enforces cooldown between swings. Timing is frame-based, derived from the VGA vertical blank.

Parameters:
SWING_FRAMES, 8, frames in the forward swing phase (1..15)
STEP_PX, 4, anim_x_offset increment per swing frame (pixels)
RECOVER_FRAMES, 4, frames offset decays back to 0 (1..15)
COOLDOWN_FRAMES, 10, frames after recovery during which clicks are refused (0..15)
HIT_FIRST, 2, first swing frame index (0-based) where hit_window is high
HIT_LAST, 5, last swing frame index where hit_window is high (HIT_FIRST <= HIT_LAST < SWING_FRAMES)

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
vblnk  in  1  vertical blank from the VGA timing chain; rising edge = frame tick
mouse_left  in  1  raw left-button level (already synchronised to clk)
flip_hor  in  1  player facing (1 = left)
game_active  in  2  nonzero = gameplay running
attack_active  out  1  high while the weapon is drawn (drives mouse_clicked of draw stage)
anim_x_offset  out  12  horizontal swing offset, unsigned pixels
flip_hor_melee  out  1  facing latched at attack start
hit_window  out  1  high during the damaging part of the swing
busy  out  1  high in any state except IDLE
attack_cnt  out  8  number of attacks started since reset, wraps 255->0

Behaviour:
- All outputs are registered. Reset (async) values: state IDLE, all outputs 0, frame counter 0.
- frame_tick = vblnk & ~vblnk_q (one-clk pulse). click = mouse_left & ~mouse_left_q. Both edge registers reset to 0.
- States: IDLE, SWING, RECOVER, COOLDOWN. Register frame_cnt[3:0].
- IDLE: on click with game_active != 0 -> SWING on the next clk, frame_cnt=0, anim_x_offset=0, flip_hor_melee<=flip_hor, attack_cnt+1, attack_active=1. Starts on click, not on tick.
- SWING: on each frame_tick, frame_cnt+1 and anim_x_offset+=STEP_PX. When frame_cnt==SWING_FRAMES-1 at a tick -> RECOVER, frame_cnt=0. The offset peaks at (SWING_FRAMES-1)*STEP_PX.
- RECOVER: on each tick, anim_x_offset -= peak/RECOVER_FRAMES (integer divide, computed from parameters at elaboration). On the last tick (frame_cnt==RECOVER_FRAMES-1) the offset is forced to 0, attack_active=0, then -> COOLDOWN. If COOLDOWN_FRAMES==0 -> IDLE instead.
- COOLDOWN: attack_active=0. Count ticks; after COOLDOWN_FRAMES ticks -> IDLE.
- hit_window = (state==SWING) && HIT_FIRST <= frame_cnt <= HIT_LAST. Registered, aligned with anim_x_offset.
- flip_hor is sampled only at attack start; changes mid-swing are ignored.
- Clicks in SWING/RECOVER/COOLDOWN are ignored (unless the optional feature is enabled).
- game_active==0 in any state: next clk -> IDLE; attack_active, hit_window and anim_x_offset are 0. The buffered click (if any) is cleared. attack_cnt is kept.
- Click and frame_tick in the same clk in IDLE: the attack starts, and that tick does not advance frame_cnt.
- Width: offset arithmetic is 12-bit unsigned. Parameters guarantee no overflow or underflow (forcing 0 at the end of RECOVER absorbs the divide remainder).

Optional Feature:
MELEE_CLICK_BUFFER_EN
- Defined: a one-deep click_pending flag sets on a click in RECOVER or COOLDOWN. On entry to IDLE with click_pending=1, the next attack starts on the following clk and the flag clears. The flag is cleared by reset and by game_active==0.
- Undefined: no flag; those clicks are dropped.

Decomposition:
- vga_pkg gets melee_state_t (enum of the 4 states) and default timing localparams (MELEE_SWING_FRAMES, etc.).
- One natural sub-module: edge_detect, a rising-edge detector with async reset. It is instantiated twice (vblnk, mouse_left) and reusable elsewhere.

Test Plan:
- Basic swing (defaults): click in IDLE, then 8 ticks -> attack_active=1 next clk; offset 0,4,...,28; hit_window high only at frame_cnt 2..5; RECOVER takes offset to 0 in 4 ticks; IDLE after 10 more ticks; attack_cnt=1.
- Facing latch: flip_hor=1 at click, toggle to 0 at tick 3 -> flip_hor_melee stays 1 for the whole attack.
- Cooldown reject (feature off): click during COOLDOWN -> no new attack; attack_cnt unchanged; next IDLE click starts an attack.
- Buffered click (MELEE_CLICK_BUFFER_EN): click at RECOVER tick 1 -> new SWING starts 1 clk after entering IDLE; attack_cnt=2.
- Abort: game_active->0 at SWING tick 4 -> next clk IDLE, attack_active=0, anim_x_offset=0, hit_window=0.
- Reset mid-attack: assert rst asynchronously, between clk edges, during SWING -> all outputs 0 immediately; click after release starts a fresh attack with attack_cnt=1.
